demux1to8_stage: RTL and testbench
==================================

# demux1to8_stage

Registered 1-to-8 demultiplexer stage that routes one 32-bit word to one of eight destination channels selected by a 3-bit destination code. It is the producer-side counterpart of the 8-to-1 selection path: it fans a single source, such as the write-back/result bus, out to eight consumers under valid/ready flow control. It holds at most one word, gives one-cycle latency, and sustains full throughput with back-to-back transfers.

## Interface
- DATA_W, 32, word width.
- TIMEOUT, 16, cycles a held word waits before it is dropped (only with DEMUX_TIMEOUT_EN); legal range 2..65535.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  word to route.
- in_sel  in  3  destination channel 0..7.
- in_valid  in  1  source offers in_data/in_sel.
- in_ready  out  1  stage accepts this cycle.
- out_data  out  DATA_W  held word, shared by all channels.
- out_valid  out  8  one-hot; bit k means the word targets channel k.
- out_ready  in  8  per-channel ready.
- drop_pulse  out  1  one-cycle pulse when a held word is discarded; constant 0 without DEMUX_TIMEOUT_EN.

## Operation
- Two states: EMPTY and FULL. Registered state is full_q, sel_q[2:0], data_q.
- accept = in_valid & in_ready. drain = full_q & out_ready[sel_q]. drop is described under Configuration.
- in_ready = ~full_q | drain | drop. This is combinational, so the stage can take a new word on the same cycle it releases the current one.
- out_valid = full_q ? (8'b1 << sel_q) : 8'b0. Exactly one bit is set when FULL.
- out_data = data_q. data_q is loaded only on accept and keeps its value while EMPTY.
- State transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on (drain | drop) & ~accept.
  - FULL→FULL on accept together with drain or drop. This reloads data_q and sel_q.
  - Otherwise the state holds.
- out_ready bits for non-selected channels are ignored. in_sel is sampled only on accept.
- While FULL and not draining, data_q and sel_q do not change, even if in_valid or in_sel toggle.
- Every value of in_sel is legal; there is no error case.

## Timing
- Reset (async assert, sync release) values:
  - full_q=0, sel_q=0, data_q=0, timeout counter=0.
  - Resulting outputs: out_valid=8'h00, out_data=0, drop_pulse=0, in_ready=1.
- Latency: a word accepted at edge N is visible on out_valid/out_data from edge N to N+1.
- Throughput: 1 word per cycle when the destination holds out_ready high.
- If rst_n asserts mid-transfer, the held word is lost and no drop_pulse is generated.

## Configuration
- Macro DEMUX_TIMEOUT_EN.
- When defined:
  - A wait counter clears on every accept and increments each cycle the stage is FULL with no drain.
  - drop = full_q & ~drain & (count == TIMEOUT-1). The word is therefore discarded on the TIMEOUT-th consecutive unaccepted cycle.
  - drop_pulse = drop, registered-free (same cycle).
  - drain takes priority over drop when both would occur in the same cycle.
- When undefined: no counter is built, drop is 0, and drop_pulse is tied 0. A word waits indefinitely.

## Structure
- Package demux_pkg holds:
  - NUM_OUT=8 and SEL_W=3.
  - The state enum {DMX_EMPTY, DMX_FULL}.
  - The default TIMEOUT constant.
- One sub-module is natural: demux_wait_timer, the timeout counter with clear/enable/expire. It is instantiated only under DEMUX_TIMEOUT_EN.

## Test plan
- Reset: assert rst_n=0 mid-run with the stage FULL → out_valid=8'h00, out_data=0, in_ready=1 immediately.
- Single route: in_data=32'hDEAD_BEEF, in_sel=5, out_ready=8'h20 → next cycle out_valid=8'h20 and out_data=DEAD_BEEF; EMPTY after one cycle.
- Back-pressure: in_sel=2, out_ready=8'hFB for 5 cycles → out_valid stays 8'h04, data is stable, in_ready=0, and a changing in_data is ignored.
- Back-to-back streaming: sel sequence 0..7, out_ready=8'hFF, in_valid held high → 8 words in 8 cycles, each one-hot in order, in_ready constantly 1.
- Simultaneous drain+accept: FULL with sel=3, out_ready[3]=1, new word with sel=6 → next cycle out_valid=8'h40 and no bubble.
- Timeout (DEMUX_TIMEOUT_EN, TIMEOUT=16): sel=1, out_ready=0 → drop_pulse high for exactly one cycle on the 16th FULL cycle, then out_valid=0. Repeat with out_ready[1] raised on that same cycle → handshake occurs and drop_pulse=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, state encoding and helpers for the demux1to8_stage block.
package demux_pkg;

    localparam int unsigned NUM_OUT         = 8;
    localparam int unsigned SEL_W           = 3;
    localparam int unsigned DEFAULT_TIMEOUT = 16;
    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int unsigned CNT_W           = 16;

    typedef enum logic {
        DMX_EMPTY = 1'b0,
        DMX_FULL  = 1'b1
    } dmx_state_e;

    // One-hot decode of a destination code.
    function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] vec;
        vec = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux1to8_stage_if.sv
// Source/sink bundle for demux1to8_stage: one input word with a destination
// code, fanned out to eight one-hot valid lanes that share a single data bus.
interface demux1to8_stage_if
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0]  in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic               drop_pulse;

    // Environment side: drives the source and the per-channel readies.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_pulse
    );

    // Demux stage side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_pulse
    );
endinterface

// File: rtl/demux_wait_timer.sv
// Wait counter for a held word: clears on request, counts while enabled and
// flags the last allowed cycle (count == TIMEOUT-1).
module demux_wait_timer
    import demux_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    // Counter register; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry flag from the registered count, so it never loops back through ready.
    always_comb begin
        expire = (count_q == LAST);
    end

endmodule

// File: rtl/demux1to8_stage.sv
// Registered 1-to-8 demultiplexer stage with valid/ready flow control.
// Holds at most one word; a new word may be accepted in the same cycle the
// held one drains, giving one word per cycle with one-cycle latency.
// Optional feature: define DEMUX_TIMEOUT_EN to drop a word that has waited
// TIMEOUT consecutive cycles without being taken.
module demux1to8_stage
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1to8_stage_if.slave  bus
);
    dmx_state_e        state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] data_q;

    logic full;
    logic drain;
    logic drop;
    logic ready;
    logic accept;

    // Handshake terms; only the selected channel's ready matters.
    always_comb begin
        full   = (state_q == DMX_FULL);
        drain  = full & bus.out_ready[sel_q];
        ready  = ~full | drain | drop;
        accept = bus.in_valid & ready;
    end

`ifdef DEMUX_TIMEOUT_EN
    logic expire;

    demux_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept | drop),
        .enable (full & ~drain),
        .expire (expire)
    );

    // Drain has priority: a word taken on its last cycle is not dropped.
    always_comb begin
        drop = full & ~drain & expire;
    end
`else
    logic unused_timeout;

    // Without the timer a held word waits indefinitely.
    always_comb begin
        drop           = 1'b0;
        unused_timeout = (TIMEOUT > 32'd1);
    end
`endif

    // State, destination and data registers; data only moves on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMX_EMPTY;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                state_q <= DMX_FULL;
                sel_q   <= bus.in_sel;
                data_q  <= bus.in_data;
            end else if (drain || drop) begin
                state_q <= DMX_EMPTY;
            end
        end
    end

    // Output decode from the registered state.
    always_comb begin
        bus.in_ready   = ready;
        bus.out_data   = data_q;
        bus.out_valid  = full ? sel_onehot(sel_q) : '0;
        bus.drop_pulse = drop;
    end

endmodule

// File: tb/tb_demux1to8_stage.sv
// Self-checking bench for demux1to8_stage. A scoreboard queue holds the word
// the stage should be holding; every cycle the outputs are compared against it.
// Define DEMUX_TIMEOUT_EN on both bench and RTL to exercise the drop path.
module tb_demux1to8_stage;
    import demux_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    demux1to8_stage_if #(.DATA_W(DW)) ifc ();

    demux1to8_stage #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   held   = 0;
    int   drops  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: check outputs at negedge against the model, update the
    // model with the handshake that happens at the next posedge.
    task automatic cycle();
        logic [7:0] exp_valid;
        logic       had;
        logic       drain;
        logic       exp_drop;
        logic       exp_ready;
        @(negedge clk);
        had       = (sb.size() != 0);
        exp_valid = had ? (8'b1 << sb[0].sel) : 8'h00;
        drain     = had && ifc.out_ready[sb[0].sel];
        exp_drop  = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
        exp_drop  = had && !drain && (held == TO - 1);
`endif
        exp_ready = !had || drain || exp_drop;
        chk("out_valid", {24'h0, ifc.out_valid}, {24'h0, exp_valid});
        if (had) chk("out_data", ifc.out_data, sb[0].data);
        chk("in_ready", {31'h0, ifc.in_ready}, {31'h0, exp_ready});
        chk("drop_pulse", {31'h0, ifc.drop_pulse}, {31'h0, exp_drop});
        if (exp_drop) drops++;
        if (drain || exp_drop) void'(sb.pop_front());
        if (ifc.in_valid && exp_ready) begin
            sb.push_back('{ifc.in_sel, ifc.in_data});
            held = 0;
        end else if (had && !drain) begin
            held++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] sel, input logic [DW-1:0] data);
        ifc.in_valid = 1'b1;
        ifc.in_sel   = sel;
        ifc.in_data  = data;
    endtask

    initial begin
        int d0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_sel    = '0;
        ifc.in_data   = '0;
        ifc.out_ready = '0;
        #1;
        chk("rst_out_valid", {24'h0, ifc.out_valid}, 32'h0);
        chk("rst_out_data", ifc.out_data, 32'h0);
        chk("rst_in_ready", {31'h0, ifc.in_ready}, 32'h1);
        chk("rst_drop", {31'h0, ifc.drop_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single route to channel 5.
        ifc.out_ready = 8'h20;
        send(3'd5, 32'hDEAD_BEEF);
        cycle();
        ifc.in_valid = 1'b0;
        chk("single_valid", {24'h0, ifc.out_valid}, 32'h20);
        chk("single_data", ifc.out_data, 32'hDEAD_BEEF);
        cycle();
        cycle();
        chk("single_empty", {24'h0, ifc.out_valid}, 32'h0);

        // Back-pressure on channel 2 while the source keeps changing.
        ifc.out_ready = 8'hFB;
        send(3'd2, 32'h1234_5678);
        cycle();
        for (int i = 0; i < 5; i++) begin
            send(3'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        chk("bp_valid", {24'h0, ifc.out_valid}, 32'h04);
        chk("bp_data", ifc.out_data, 32'h1234_5678);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 8'hFF;
        cycle();
        cycle();
        cycle();

        // Back-to-back streaming across all channels.
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 32'hA000_0000 | 32'(i));
            cycle();
        end
        ifc.in_valid = 1'b0;
        cycle();
        chk("stream_empty", {24'h0, ifc.out_valid}, 32'h0);

        // Drain of channel 3 and accept for channel 6 in the same cycle.
        ifc.out_ready = 8'h00;
        send(3'd3, 32'h3333_3333);
        cycle();
        ifc.in_valid = 1'b0;
        cycle();
        ifc.out_ready = 8'h08;
        send(3'd6, 32'h6666_6666);
        cycle();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 8'h00;
        chk("nobubble_valid", {24'h0, ifc.out_valid}, 32'h40);
        chk("nobubble_data", ifc.out_data, 32'h6666_6666);
        ifc.out_ready = 8'h40;
        cycle();
        cycle();

`ifdef DEMUX_TIMEOUT_EN
        // Word on channel 1 never taken: dropped on its 16th full cycle.
        ifc.out_ready = 8'h00;
        d0 = drops;
        send(3'd1, 32'h0101_0101);
        cycle();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < TO; i++) cycle();
        chk("drop_count", 32'(drops - d0), 32'd1);
        chk("drop_after_valid", {24'h0, ifc.out_valid}, 32'h0);
        cycle();
        // Same again, but the channel becomes ready on the last cycle.
        d0 = drops;
        send(3'd1, 32'h0202_0202);
        cycle();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < TO - 1; i++) cycle();
        ifc.out_ready = 8'h02;
        cycle();
        chk("drain_wins_count", 32'(drops - d0), 32'd0);
        chk("drain_wins_valid", {24'h0, ifc.out_valid}, 32'h0);
`else
        // Without the timer a word waits as long as it takes.
        ifc.out_ready = 8'h00;
        d0 = drops;
        send(3'd1, 32'h0101_0101);
        cycle();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < TO + 4; i++) cycle();
        chk("hold_valid", {24'h0, ifc.out_valid}, 32'h02);
        chk("hold_drop_count", 32'(drops - d0), 32'd0);
        ifc.out_ready = 8'h02;
        cycle();
        cycle();
`endif

        // Reset while FULL loses the word immediately.
        ifc.out_ready = 8'h00;
        send(3'd4, 32'hCAFE_F00D);
        cycle();
        ifc.in_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {24'h0, ifc.out_valid}, 32'h0);
        chk("midrst_data", ifc.out_data, 32'h0);
        chk("midrst_ready", {31'h0, ifc.in_ready}, 32'h1);
        chk("midrst_drop", {31'h0, ifc.drop_pulse}, 32'h0);
        sb.delete();
        held = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
